// File: rtl/basemul_pkg.sv
// basemul_pkg: state encoding, output bundle and defaults shared by the basemul control FSM
package basemul_pkg;
    localparam int DEPTH_DEF = 8;
    localparam int PIPE_LAT_DEF = 5;
    localparam int KMAX_DEF = 4;
    typedef enum logic [2:0] {LOAD_P, LOAD_W, ARM, CLR, FILL, RUN, DRAIN, OUT} state_t;
    typedef struct packed {
        logic iscal;
        logic index_a;
        logic index_b;
        logic index_c;
        logic counter_ctrl;
        logic rama_we;
        logic ramb_we;
        logic ramc_we;
        logic readin_a;
        logic readin_b;
        logic cal_pulse;
        logic done;
    } ctrl_t;
    function automatic int npair(input int depth);
        return 1 << (depth - 1);
    endfunction
    // Zero batches means one; anything past kmax is clamped.
    function automatic logic [2:0] clamp_k(input logic [2:0] k, input int kmax);
        return (k == 3'd0) ? 3'd1 : ((int'(k) > kmax) ? 3'(kmax) : k);
    endfunction
endpackage

// File: rtl/basemul_ctrl_fsm_if.sv
// basemul_ctrl_fsm_if: host/datapath handshake bundle around the basemul control FSM
interface basemul_ctrl_fsm_if #(parameter int DEPTH = basemul_pkg::DEPTH_DEF) ();
    logic mode, full_in, cal_en, readout;
    logic [2:0] k_batches;
    logic iscal, index_a_ctrl, index_b_ctrl, index_c_ctrl, counter_ctrl;
    logic rama_we_ok, ramb_we_ok, ramc_we_ok, readin_a_ok, readin_b_ok;
    logic cal_pulse, acc_en, done;
    logic [2:0] batch_idx;
    logic [DEPTH:0] counter;
    modport master (
        output mode, k_batches, full_in, cal_en, readout,
        input iscal, index_a_ctrl, index_b_ctrl, index_c_ctrl, counter_ctrl,
        input rama_we_ok, ramb_we_ok, ramc_we_ok, readin_a_ok, readin_b_ok,
        input cal_pulse, acc_en, done, batch_idx, counter
    );
    modport slave (
        input mode, k_batches, full_in, cal_en, readout,
        output iscal, index_a_ctrl, index_b_ctrl, index_c_ctrl, counter_ctrl,
        output rama_we_ok, ramb_we_ok, ramc_we_ok, readin_a_ok, readin_b_ok,
        output cal_pulse, acc_en, done, batch_idx, counter
    );
endinterface

// File: rtl/basemul_cycle_counter.sv
// basemul_cycle_counter: per-batch cycle counter with the FILL/RUN/DRAIN terminal compares
module basemul_cycle_counter import basemul_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           en,
    output logic [DEPTH:0] count,
    output logic           fill_end,
    output logic           run_end,
    output logic           drain_end
);
    localparam int CW = DEPTH + 1;
    localparam int NP = npair(DEPTH);
    always_ff @(posedge clk)
        if (clr) count <= '0;
        else if (en) count <= count + 1'b1;
    assign fill_end = count == CW'(PIPE_LAT - 1);
    assign run_end = count == CW'(NP - 1);
    assign drain_end = count == CW'(NP + PIPE_LAT - 1);
endmodule

// File: rtl/basemul_ctrl_fsm.sv
// basemul_ctrl_fsm: load/compute/readout sequencer for the Kyber basemul and tomont datapath
module basemul_ctrl_fsm import basemul_pkg::*; #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int KMAX = KMAX_DEF
) (
    input logic clk,
    input logic reset,
    input logic set,
    basemul_ctrl_fsm_if.slave bus
);
    state_t state, next_state;
    ctrl_t ctrl, ctrl_d;
    logic mode_q, m_eff, new_job, last_batch, acc_en;
    logic [2:0] k_q, batch_idx;
    logic fill_end, run_end, drain_end;
    logic [DEPTH:0] count;
    logic ld, comp, feed;
    basemul_cycle_counter #(.DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) u_cnt (
        .clk(clk),
        .clr(ctrl.cal_pulse || reset),
        .en(ctrl.counter_ctrl && set),
        .count(count),
        .fill_end(fill_end),
        .run_end(run_end),
        .drain_end(drain_end)
    );
    // Mode follows the live input only while a new job is being set up; otherwise the latched job mode.
    assign new_job = (state == OUT) || (state == LOAD_P && batch_idx == 3'd0);
    assign m_eff = new_job ? bus.mode : mode_q;
    assign last_batch = batch_idx >= k_q - 3'd1;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_P;
            ctrl <= '0;
            mode_q <= 1'b0;
            k_q <= 3'd1;
            batch_idx <= 3'd0;
            acc_en <= 1'b0;
        end else if (set) begin
            state <= next_state;
            ctrl <= ctrl_d;
            if (state == LOAD_P && batch_idx == 3'd0) begin
                mode_q <= bus.mode;
                k_q <= clamp_k(bus.k_batches, KMAX);
            end
            if (state == DRAIN && drain_end && !last_batch) begin
                batch_idx <= batch_idx + 3'd1;
                acc_en <= 1'b1;
            end
            if (state == OUT && bus.readout) begin
                batch_idx <= 3'd0;
                acc_en <= 1'b0;
            end
        end
    end
    always_comb begin
        next_state = state;
        case (state)
            LOAD_P: next_state = LOAD_W;
            LOAD_W: next_state = bus.full_in ? ARM : LOAD_W;
            ARM: next_state = bus.cal_en ? CLR : ARM;
            CLR: next_state = FILL;
            FILL: next_state = fill_end ? RUN : FILL;
            RUN: next_state = run_end ? DRAIN : RUN;
            DRAIN: next_state = drain_end ? (last_batch ? OUT : LOAD_P) : DRAIN;
            OUT: next_state = bus.readout ? LOAD_P : OUT;
            default: next_state = LOAD_P;
        endcase
    end
    // Outputs are decoded from the state being entered so they line up with it once registered.
    always_comb begin
        ld = next_state == LOAD_P || next_state == LOAD_W;
        feed = next_state == FILL || next_state == RUN;
        comp = feed || next_state == DRAIN;
        ctrl_d = '0;
        ctrl_d.iscal = comp;
        ctrl_d.counter_ctrl = comp;
        ctrl_d.index_a = feed;
        ctrl_d.index_b = feed && !m_eff;
        ctrl_d.index_c = next_state == RUN || next_state == DRAIN || next_state == OUT;
        ctrl_d.rama_we = ld;
        ctrl_d.ramb_we = ld && !m_eff;
        ctrl_d.ramc_we = next_state == RUN || next_state == DRAIN;
        ctrl_d.readin_a = next_state == LOAD_P;
        ctrl_d.readin_b = next_state == LOAD_P && !m_eff;
        ctrl_d.cal_pulse = next_state == CLR;
        ctrl_d.done = next_state == OUT;
    end
    assign bus.iscal = ctrl.iscal;
    assign bus.index_a_ctrl = ctrl.index_a;
    assign bus.index_b_ctrl = ctrl.index_b;
    assign bus.index_c_ctrl = ctrl.index_c;
    assign bus.counter_ctrl = ctrl.counter_ctrl;
    assign bus.rama_we_ok = ctrl.rama_we;
    assign bus.ramb_we_ok = ctrl.ramb_we;
    assign bus.ramc_we_ok = ctrl.ramc_we;
    assign bus.readin_a_ok = ctrl.readin_a;
    assign bus.readin_b_ok = ctrl.readin_b;
    assign bus.cal_pulse = ctrl.cal_pulse;
    assign bus.done = ctrl.done;
    assign bus.acc_en = acc_en;
    assign bus.batch_idx = batch_idx;
    assign bus.counter = count;
endmodule

// File: tb/tb_basemul_ctrl_fsm.sv
// tb_basemul_ctrl_fsm: scoreboard bench for basemul_ctrl_fsm with DEPTH=8, PIPE_LAT=5, KMAX=4
module tb_basemul_ctrl_fsm;
    import basemul_pkg::*;
    localparam int LAT = 128 + 5 + 2;
    typedef struct {int batch; bit acc; bit last; bit mode; int lat;} exp_t;
    logic clk = 1'b0, reset = 1'b1, set = 1'b1;
    int vectors = 0, miscompares = 0;
    exp_t sb[$];
    logic [12:0] outs;
    basemul_ctrl_fsm_if #(.DEPTH(8)) bus ();
    basemul_ctrl_fsm #(.DEPTH(8), .PIPE_LAT(5), .KMAX(4)) dut (
        .clk(clk), .reset(reset), .set(set), .bus(bus)
    );
    assign outs = {bus.iscal, bus.index_a_ctrl, bus.index_b_ctrl, bus.index_c_ctrl, bus.counter_ctrl,
                   bus.rama_we_ok, bus.ramb_we_ok, bus.ramc_we_ok, bus.readin_a_ok, bus.readin_b_ok,
                   bus.cal_pulse, bus.acc_en, bus.done};
    always #5 clk = ~clk;

    task automatic wait_load_w();
        int t = 0;
        while (!(bus.rama_we_ok === 1'b1 && bus.readin_a_ok === 1'b0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (t >= 20) begin miscompares++; $display("FAIL load_w_timeout: waited %0d cycles, limit 20", t); end
    endtask

    // One batch: load handshake, go, then monitor until done or the next LOAD_P.
    task automatic run_batch(input int b, input bit last, input bit m, input int stall_at, input int reset_at, input bit early);
        exp_t e;
        int n = 0, rc = 0, first_c = -1, cp = 0, bi = -1, hold_bad = 0;
        bit b_any = 0, ac = 0, stalled = 0;
        wait_load_w();
        if (early) begin
            bus.cal_en = 1'b1;
            repeat (3) @(negedge clk);
            vectors++;
            if ({bus.rama_we_ok, bus.cal_pulse, bus.iscal} !== 3'b100) begin
                miscompares++;
                $display("FAIL cal_en_in_load_w: we/cal_pulse/iscal=%b want 100", {bus.rama_we_ok, bus.cal_pulse, bus.iscal});
            end
        end
        bus.full_in = 1'b1;
        @(negedge clk);
        bus.full_in = 1'b0;
        vectors++;
        if ({bus.rama_we_ok, bus.ramb_we_ok, bus.cal_pulse} !== 3'b000) begin
            miscompares++;
            $display("FAIL arm_entry: rama/ramb/cal_pulse=%b want 000", {bus.rama_we_ok, bus.ramb_we_ok, bus.cal_pulse});
        end
        sb.push_back('{b, b > 0, last, m, LAT + ((stall_at >= 0) ? 10 : 0)});
        bus.cal_en = 1'b1;
        while (1) begin
            @(negedge clk);
            n++;
            bus.cal_en = (n == 20);
            bus.readout = (n == 20);
            if (bus.ramc_we_ok === 1'b1) begin
                rc++;
                if (first_c < 0) first_c = int'(bus.counter);
            end
            if ((bus.ramb_we_ok | bus.index_b_ctrl | bus.readin_b_ok) !== 1'b0) b_any = 1;
            if (bus.iscal === 1'b1) begin bi = int'(bus.batch_idx); ac = bus.acc_en; end
            if (bus.cal_pulse === 1'b1) cp++;
            if (reset_at >= 0 && int'(bus.counter) == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                vectors++;
                if (outs !== 13'd0) begin miscompares++; $display("FAIL reset_mid_outputs: got %b want 0", outs); end
                vectors++;
                if (bus.counter !== 9'd0 || bus.batch_idx !== 3'd0) begin
                    miscompares++;
                    $display("FAIL reset_mid_counter: counter=%0d batch=%0d want 0 0", bus.counter, bus.batch_idx);
                end
                vectors++;
                if (dut.state !== LOAD_P) begin miscompares++; $display("FAIL reset_mid_state: got %0d want %0d", dut.state, LOAD_P); end
                void'(sb.pop_front());
                return;
            end
            if (stall_at >= 0 && !stalled && int'(bus.counter) == stall_at) begin
                stalled = 1;
                set = 1'b0;
                repeat (10) begin
                    @(negedge clk);
                    n++;
                    if (int'(bus.counter) != stall_at || bus.ramc_we_ok !== 1'b1) hold_bad++;
                end
                set = 1'b1;
            end
            if (bus.done === 1'b1 || bus.readin_a_ok === 1'b1 || n > 400) break;
        end
        vectors++;
        if (sb.size() == 0) begin miscompares++; $display("FAIL scoreboard_empty: size 0 want 1"); return; end
        e = sb.pop_front();
        vectors++;
        if (n != e.lat) begin miscompares++; $display("FAIL batch%0d_latency: got %0d want %0d", e.batch, n, e.lat); end
        vectors++;
        if (bus.done !== e.last) begin miscompares++; $display("FAIL batch%0d_done: got %b want %b", e.batch, bus.done, e.last); end
        vectors++;
        if (rc != 128) begin miscompares++; $display("FAIL batch%0d_ramc_cycles: got %0d want 128", e.batch, rc); end
        vectors++;
        if (first_c != 5) begin miscompares++; $display("FAIL batch%0d_ramc_start: got %0d want 5", e.batch, first_c); end
        vectors++;
        if (bi != e.batch) begin miscompares++; $display("FAIL batch_idx: got %0d want %0d", bi, e.batch); end
        vectors++;
        if (ac !== e.acc) begin miscompares++; $display("FAIL batch%0d_acc_en: got %b want %b", e.batch, ac, e.acc); end
        vectors++;
        if (b_any !== !e.mode) begin miscompares++; $display("FAIL batch%0d_b_path: got %b want %b", e.batch, b_any, !e.mode); end
        vectors++;
        if (cp != 1) begin miscompares++; $display("FAIL batch%0d_cal_pulse: got %0d cycles want 1", e.batch, cp); end
        if (stall_at >= 0) begin
            vectors++;
            if (hold_bad != 0) begin miscompares++; $display("FAIL stall_hold: %0d bad cycles want 0", hold_bad); end
        end
        if (e.last) begin
            vectors++;
            if ({bus.iscal, bus.counter_ctrl, bus.index_c_ctrl, bus.ramc_we_ok} !== 4'b0010) begin
                miscompares++;
                $display("FAIL out_outputs: iscal/cnt/idx_c/ramc=%b want 0010", {bus.iscal, bus.counter_ctrl, bus.index_c_ctrl, bus.ramc_we_ok});
            end
        end else begin
            vectors++;
            if ({bus.readin_b_ok, bus.acc_en, bus.iscal} !== {!e.mode, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL next_load_p: rb/acc/iscal=%b want %b", {bus.readin_b_ok, bus.acc_en, bus.iscal}, {!e.mode, 2'b10});
            end
            @(negedge clk);
            vectors++;
            if ({bus.readin_a_ok, bus.rama_we_ok} !== 2'b01) begin
                miscompares++;
                $display("FAIL readin_width: ra/we=%b want 01", {bus.readin_a_ok, bus.rama_we_ok});
            end
        end
    endtask

    task automatic run_job(input bit m, input int kexp, input int stall_at, input bit flip);
        for (int b = 0; b < kexp; b++) begin
            run_batch(b, b == kexp - 1, m, stall_at, -1, 1'b0);
            if (flip && b == 0) bus.mode = ~m;
        end
    endtask

    task automatic finish_job(input bit nm, input logic [2:0] nk);
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.done !== 1'b1) begin miscompares++; $display("FAIL done_hold: got %b want 1", bus.done); end
        bus.mode = nm;
        bus.k_batches = nk;
        bus.readout = 1'b1;
        @(negedge clk);
        bus.readout = 1'b0;
        vectors++;
        if ({bus.done, bus.readin_a_ok, bus.readin_b_ok, bus.ramb_we_ok, bus.acc_en, bus.batch_idx} !== {1'b0, 1'b1, !nm, !nm, 1'b0, 3'd0}) begin
            miscompares++;
            $display("FAIL readout_to_load_p: got %b want %b", {bus.done, bus.readin_a_ok, bus.readin_b_ok, bus.ramb_we_ok, bus.acc_en, bus.batch_idx},
                     {1'b0, 1'b1, !nm, !nm, 1'b0, 3'd0});
        end
        @(negedge clk);
        vectors++;
        if (bus.readin_a_ok !== 1'b0) begin miscompares++; $display("FAIL readin_pulse_width: got %b want 0", bus.readin_a_ok); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set = 1'b1;
        bus.mode = 1'b0;
        bus.k_batches = 3'd1;
        bus.full_in = 1'b0;
        bus.cal_en = 1'b0;
        bus.readout = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (outs !== 13'd0) begin miscompares++; $display("FAIL reset_outputs: got %b want 0", outs); end
        vectors++;
        if (bus.counter !== 9'd0 || bus.batch_idx !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_counter: counter=%0d batch=%0d want 0 0", bus.counter, bus.batch_idx);
        end
        vectors++;
        if (dut.state !== LOAD_P) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state, LOAD_P); end
        reset = 1'b0;
    endtask

    task automatic test_basemul();
        run_job(1'b0, 1, -1, 1'b0);
        finish_job(1'b1, 3'd1);
    endtask

    task automatic test_tomont();
        run_job(1'b1, 1, -1, 1'b0);
        finish_job(1'b0, 3'd3);
    endtask

    task automatic test_multi_batch();
        run_job(1'b0, 3, -1, 1'b1);
        finish_job(1'b0, 3'd0);
    endtask

    task automatic test_k_clamp();
        run_job(1'b0, 1, -1, 1'b0);
        finish_job(1'b0, 3'd7);
        run_job(1'b0, 4, -1, 1'b0);
        finish_job(1'b0, 3'd1);
    endtask

    task automatic test_stall();
        run_job(1'b0, 1, 60, 1'b0);
        finish_job(1'b0, 3'd2);
    endtask

    task automatic test_reset_mid();
        run_batch(0, 1'b0, 1'b0, -1, -1, 1'b0);
        bus.k_batches = 3'd1;
        run_batch(1, 1'b0, 1'b0, -1, 100, 1'b0);
    endtask

    task automatic test_cal_held();
        run_batch(0, 1'b1, 1'b0, -1, -1, 1'b1);
        finish_job(1'b0, 3'd1);
    endtask

    initial begin
        test_reset();
        test_basemul();
        test_tomont();
        test_multi_batch();
        test_k_clamp();
        test_stall();
        test_reset_mid();
        test_cal_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/basemul_ctrl_fsm.md
# basemul_ctrl_fsm

Parametrised control FSM for the Kyber base-multiplication / to-Montgomery datapath. It sequences load, compute and readout of coefficient RAMs A, B and C, and owns the cycle counter internally instead of taking it as an input. It adds three things:

- a configurable pipeline latency,
- a tomont-only mode,
- multi-batch accumulation, so one job computes Σ a_i·b_i over k polynomial pairs (matrix-vector row), with a readout handshake before the next job.

It sits between the host load/readout logic and the basemul datapath/RAM index generators.

## Interface
Parameters:
- DEPTH, 8: RAM index width. One batch is NPAIR = 2^(DEPTH-1) coefficient-pair steps.
- PIPE_LAT, 5: datapath latency in cycles from A/B read to C write. Legal range is 1..NPAIR-1.
- KMAX, 4: maximum batches per job.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high. Overrides set.
- set, in, 1: global clock enable. When 0, all state, counter and outputs hold.
- mode, in, 1: 0 = basemul (A·B), 1 = tomont-only (A only). Sampled in LOAD_P.
- k_batches, in, 3: batches per job. 0 is treated as 1; values above KMAX are clamped to KMAX. Sampled in LOAD_P of batch 0 only.
- full_in, in, 1: input RAM(s) loaded.
- cal_en, in, 1: host go.
- readout, in, 1: host finished reading C.
- iscal, out, 1: datapath busy.
- index_a_ctrl, index_b_ctrl, index_c_ctrl, out, 1 each: index generators advance.
- counter_ctrl, out, 1: counter running.
- rama_we_ok, ramb_we_ok, ramc_we_ok, out, 1 each: write-enable permissions.
- readin_a_ok, readin_b_ok, out, 1 each: load-request pulses.
- cal_pulse, out, 1: clear pulse for index/counter.
- acc_en, out, 1: C-write adds to existing C.
- batch_idx, out, 3: current batch number, 0..k-1.
- counter, out, DEPTH+1: internal cycle count.
- done, out, 1: job result available.

## Operation
- All outputs are registered and decoded from the state being entered, so they are valid in the same cycle the FSM is in that state.
- Reset values: every output is 0, counter is 0, batch_idx is 0, state is LOAD_P.

States and transitions:
- LOAD_P: one cycle. readin_a_ok=1, and readin_b_ok=1 only if mode=0. rama_we_ok=1, and ramb_we_ok=!mode. Always goes to LOAD_W.
- LOAD_W: readin pulses return to 0. Goes to ARM when full_in=1.
- ARM: we_ok outputs go to 0. Goes to CLR when cal_en=1.
- CLR: one cycle. cal_pulse=1, counter cleared to 0. Goes to FILL.
- FILL: iscal=1, counter_ctrl=1, index_a_ctrl=1, index_b_ctrl=!mode, index_c_ctrl=0, ramc_we_ok=0. Counter increments every cycle. Goes to RUN when counter==PIPE_LAT-1.
- RUN: as FILL, plus index_c_ctrl=1 and ramc_we_ok=1. Goes to DRAIN when counter==NPAIR-1.
- DRAIN: index_a_ctrl=0, index_b_ctrl=0, C writes continue. Leaves when counter==NPAIR+PIPE_LAT-1:
  - if batch_idx<k-1: increment batch_idx, set acc_en=1, go to LOAD_P;
  - otherwise go to OUT.
- OUT: iscal=0, counter_ctrl=0, index_c_ctrl=1 (readout owns index C), done=1. On readout=1: done=0, acc_en=0, batch_idx=0, go to LOAD_P.

Arithmetic and tracking:
- The counter is DEPTH+1 bits wide. It never wraps in legal operation, because its maximum is NPAIR+PIPE_LAT-1 < 2^DEPTH.
- acc_en is 0 for all of batch 0 and 1 for batches 1..k-1. It is held from the DRAIN exit through the next DRAIN.
- mode latched at batch 0 applies to the whole job. A mode change mid-job is ignored until the next job.

## Timing
- Compute duration per batch: CLR (1 cycle) + FILL (PIPE_LAT) + RUN (NPAIR-PIPE_LAT) + DRAIN (PIPE_LAT) = NPAIR+PIPE_LAT+1 cycles.
- ramc_we_ok is high for exactly NPAIR cycles per batch.
- Latency from cal_en sampled in ARM to done=1 (k=1) is NPAIR+PIPE_LAT+2 cycles.
- Boundary behaviour:
  - full_in is ignored outside LOAD_W.
  - cal_en is ignored outside ARM, including cal_en held high since LOAD_W.
  - readout is ignored outside OUT.
  - full_in and cal_en asserted together in LOAD_W: go to ARM only; cal_en must be seen again in ARM.
  - set=0 in any state: freeze with no counter advance. Pulses stretch until set returns.
  - reset mid-compute: at the next edge all outputs are 0, state is LOAD_P, counter is 0, batch_idx is 0, acc_en is 0.
- No illegal-state lockup: any unencoded state goes to LOAD_P.

## Structure
- Package basemul_pkg holds:
  - the state encoding localparams (LOAD_P, LOAD_W, ARM, CLR, FILL, RUN, DRAIN, OUT);
  - default DEPTH and PIPE_LAT;
  - KMAX;
  - the NPAIR derivation.
- One sub-module, basemul_cycle_counter: DEPTH+1-bit counter with enable (counter_ctrl && set), synchronous clear (cal_pulse || reset), and the terminal-compare outputs fill_end, run_end and drain_end.

## Test plan
Parameters for all scenarios: DEPTH=8, PIPE_LAT=5, NPAIR=128.

1. mode=0, k=1, full_in, cal_en, then readout:
   - readin pulses are 1 cycle wide;
   - ramc_we_ok is high for 128 cycles, starting at counter=5;
   - done rises 135 cycles after cal_en;
   - readout returns the FSM to LOAD_P.
2. mode=1: readin_b_ok, ramb_we_ok and index_b_ctrl stay 0 throughout; all other timing is identical to scenario 1.
3. k=3:
   - three compute phases with batch_idx 0, 1, 2;
   - acc_en is 0 in batch 0 and 1 in batches 1 and 2;
   - done is asserted only after batch 2.
4. k=0 behaves as one batch. k=7 behaves as 4 batches.
5. set=0 for 10 cycles at counter=60: the counter holds at 60, and total compute cycles grow by exactly 10.
6. reset at counter=100 in RUN: next cycle all outputs are 0 and state is LOAD_P. Also check that cal_en held high through LOAD_W does not start compute until seen in ARM.
